axi3_ram_slave: RTL and testbench

// AXI3 responder backed by an internal word-addressed RAM. It is the target-side counterpart of the

---
 rtl/axi3_ram_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi3_ram_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_ram_slave.sv
// AXI3 target backed by an internal word-addressed RAM; serves one read or write
// burst at a time (FIXED/INCR, 1-16 beats of 32 bits).
module axi3_ram_slave #(
  parameter int          DATA_WIDTH = 32,
  parameter int          MEM_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1FC0_0000,
  parameter int          ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // read address / data
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [31:0]             araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  // write address / data / response
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [31:0]             awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  function automatic logic f_in_range(input logic [31:0] a);
    return a[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2];
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic f_hdr_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

  // WRAP and reserved bursts walk the address like INCR; the window end is not wrapped.
  function automatic logic [31:0] f_next_addr(input logic [31:0] a, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + 32'd4;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic                  last_rd_q, last_rd_d;
  logic                  err_q, err_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [31:0]           addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [2:0]            size_q, size_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic                  grant_rd;
  logic                  mem_we;
  logic [31:0]           nxt_addr;
  logic                  beat_ok;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    err_d     = err_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    burst_d   = burst_q;
    size_d    = size_q;
    id_d      = id_q;
    mem_we    = 1'b0;
    nxt_addr  = f_next_addr(addr_q, burst_q);
    beat_ok   = f_in_range(addr_q) && !f_hdr_err(size_q, burst_q);

    // Alternate between channels only when both request at once.
    if (arvalid && !awvalid)      grant_rd = 1'b1;
    else if (awvalid && !arvalid) grant_rd = 1'b0;
    else                          grant_rd = !last_rd_q;

    arready = (state_q == IDLE) && grant_rd && !rst;
    awready = (state_q == IDLE) && !grant_rd && !rst;
    wready  = (state_q == WR);
    bvalid  = (state_q == RESP);
    bid     = bvalid ? id_q : '0;
    bresp   = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

    case (state_q)
      IDLE: begin
        if (arvalid && arready) begin
          state_d   = RD;
          last_rd_d = 1'b1;
          addr_d    = araddr;
          cnt_d     = 4'd0;
          len_d     = arlen;
          burst_d   = arburst;
          size_d    = arsize;
          id_d      = arid;
          rid_d     = arid;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == 4'd0);
          rdata_d   = f_in_range(araddr) ? mem[f_idx(araddr)] : '0;
          rresp_d   = (!f_in_range(araddr) || f_hdr_err(arsize, arburst)) ? RESP_SLVERR : RESP_OKAY;
        end else if (awvalid && awready) begin
          state_d   = WR;
          last_rd_d = 1'b0;
          err_d     = 1'b0;
          addr_d    = awaddr;
          cnt_d     = 4'd0;
          len_d     = awlen;
          burst_d   = awburst;
          size_d    = awsize;
          id_d      = awid;
        end
      end
      RD: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            // Present the following beat on the same edge that retires this one.
            addr_d  = nxt_addr;
            cnt_d   = cnt_q + 4'd1;
            rlast_d = ((cnt_q + 4'd1) == len_q);
            rdata_d = f_in_range(nxt_addr) ? mem[f_idx(nxt_addr)] : '0;
            rresp_d = (!f_in_range(nxt_addr) || f_hdr_err(size_q, burst_q)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      WR: begin
        if (wvalid) begin
          mem_we = beat_ok && !rst;
          if (!beat_ok || (wlast != (cnt_q == len_q)) || (wid != id_q)) err_d = 1'b1;
          addr_d = nxt_addr;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == len_q) state_d = RESP;
        end
      end
      RESP: begin
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rid    = rid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rid_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    cnt_q   <= cnt_d;
    len_q   <= len_d;
    burst_q <= burst_d;
    size_q  <= size_d;
    id_q    <= id_d;
  end

  // Byte-lane write; lanes with a clear strobe keep their old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[f_idx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi3_ram_slave.sv
// Directed bench for axi3_ram_slave: burst reads/writes, strobes, errors,
// arbitration, backpressure and reset during a burst.
module tb_axi3_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rd_dat  [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  resp;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  axi3_ram_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Read burst with rready held high; beats land in rd_dat/rd_resp/rd_last.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    int t;
    @(posedge clk); #1;
    araddr = addr; arlen = len; arsize = 3'b010; arburst = burst; arid = 4'h3; arvalid = 1'b1;
    #1;
    t = 0;
    while (!arready && t < 20) begin @(posedge clk); #2; t++; end
    chk("ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    #1;
    chk("r_latency", rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      chk("r_valid_beat", rvalid, 1);
      chk("r_id", rid, 4'h3);
      rd_dat[i]  = rdata;
      rd_resp[i] = rresp;
      rd_last[i] = rlast;
      @(posedge clk); #2;
    end
    rready = 1'b0;
    chk("r_done", rvalid, 0);
  endtask

  // Write burst from wdat/wstb; early puts wlast on beat 0.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic early, output logic [1:0] br);
    int t;
    @(posedge clk); #1;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = 4'h5; awvalid = 1'b1;
    #1;
    t = 0;
    while (!awready && t < 20) begin @(posedge clk); #2; t++; end
    chk("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wdat[i]; wstrb = wstb[i]; wid = 4'h5; wvalid = 1'b1;
      wlast = early ? (i == 0) : (i == int'(len));
      #1;
      chk("w_ready", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    bready = 1'b1;
    #1;
    t = 0;
    while (!bvalid && t < 20) begin @(posedge clk); #2; t++; end
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, 4'h5);
    br = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
    #1;
    chk("b_done", bvalid, 0);
  endtask

  initial begin
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = INCR; arvalid = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = INCR; awvalid = 1'b1;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;

    // Reset state, with both address valids asserted
    repeat (3) @(posedge clk);
    #2;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rid", rid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    arvalid = 1'b0; awvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Simultaneous AR (out of range) and AW out of reset: read first, then write
    @(posedge clk); #1;
    araddr = 32'h0000_0000; arlen = 4'd0; arid = 4'h3; arvalid = 1'b1;
    awaddr = 32'h1FC0_0010; awlen = 4'd0; awid = 4'h5; awvalid = 1'b1;
    #1;
    chk("arb_arready", arready, 1);
    chk("arb_awready", awready, 0);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("oor_rvalid", rvalid, 1);
    chk("oor_rdata", rdata, 32'h0);
    chk("oor_rresp", rresp, 2'b10);
    chk("oor_rlast", rlast, 1);
    chk("arb_aw_blocked", awready, 0);
    @(posedge clk); #1;
    rready = 1'b0;
    #1;
    chk("oor_rdone", rvalid, 0);
    chk("arb_aw_second", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wid = 4'h5; wvalid = 1'b1;
    #1;
    chk("arb_wready", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0; bready = 1'b1;
    #1;
    chk("arb_bvalid", bvalid, 1);
    chk("arb_bresp", bresp, 2'b00);
    chk("arb_bid", bid, 4'h5);
    @(posedge clk); #1;
    bready = 1'b0;

    // Single read back of the DEADBEEF word
    axi_read(32'h1FC0_0010, 4'd0, INCR);
    chk("single_rdata", rd_dat[0], 32'hDEAD_BEEF);
    chk("single_rresp", rd_resp[0], 2'b00);
    chk("single_rlast", rd_last[0], 1);

    // Last grant was a read, so a simultaneous request now favours the write
    @(posedge clk); #1;
    araddr = 32'h1FC0_0010; arvalid = 1'b1; awaddr = 32'h1FC0_0010; awvalid = 1'b1;
    #1;
    chk("arb2_awready", awready, 1);
    chk("arb2_arready", arready, 0);
    arvalid = 1'b0; awvalid = 1'b0;

    // INCR 4-beat write then read
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    axi_write(32'h1FC0_0100, 4'd3, 3'b010, INCR, 1'b0, resp);
    chk("incr_bresp", resp, 2'b00);
    axi_read(32'h1FC0_0100, 4'd3, INCR);
    chk("incr_d0", rd_dat[0], 32'd1);
    chk("incr_d1", rd_dat[1], 32'd2);
    chk("incr_d2", rd_dat[2], 32'd3);
    chk("incr_d3", rd_dat[3], 32'd4);
    chk("incr_last0", rd_last[0], 0);
    chk("incr_last1", rd_last[1], 0);
    chk("incr_last2", rd_last[2], 0);
    chk("incr_last3", rd_last[3], 1);

    // FIXED 2-beat read repeats the same word
    axi_read(32'h1FC0_0104, 4'd1, FIXED);
    chk("fixed_d0", rd_dat[0], 32'd2);
    chk("fixed_d1", rd_dat[1], 32'd2);
    chk("fixed_last1", rd_last[1], 1);

    // Byte strobes
    wdat[0] = 32'h1122_3344; wstb[0] = 4'hF;
    axi_write(32'h1FC0_0200, 4'd0, 3'b010, INCR, 1'b0, resp);
    wdat[0] = 32'hAABB_CCDD; wstb[0] = 4'b0101;
    axi_write(32'h1FC0_0200, 4'd0, 3'b010, INCR, 1'b0, resp);
    chk("strb_bresp", resp, 2'b00);
    axi_read(32'h1FC0_0200, 4'd0, INCR);
    chk("strb_rdata", rd_dat[0], 32'h11BB_33DD);

    // Bad size: SLVERR and RAM untouched
    wdat[0] = 32'hCAFE_F00D; wstb[0] = 4'hF;
    axi_write(32'h1FC0_0010, 4'd0, 3'b001, INCR, 1'b0, resp);
    chk("size_bresp", resp, 2'b10);
    axi_read(32'h1FC0_0010, 4'd0, INCR);
    chk("size_ram_kept", rd_dat[0], 32'hDEAD_BEEF);

    // Early wlast: SLVERR but data still written
    wdat[0] = 32'h0000_0055; wstb[0] = 4'hF;
    wdat[1] = 32'h0000_0066; wstb[1] = 4'hF;
    axi_write(32'h1FC0_0300, 4'd1, 3'b010, INCR, 1'b1, resp);
    chk("wlast_bresp", resp, 2'b10);
    axi_read(32'h1FC0_0300, 4'd1, INCR);
    chk("wlast_d0", rd_dat[0], 32'h55);
    chk("wlast_d1", rd_dat[1], 32'h66);

    // Backpressure: rready low for 3 cycles on beat 1
    @(posedge clk); #1;
    araddr = 32'h1FC0_0100; arlen = 4'd3; arburst = INCR; arsize = 3'b010; arvalid = 1'b1;
    #1;
    chk("bp_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("bp_d0", rdata, 32'd1);
    @(posedge clk); #1;
    rready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", rvalid, 1);
      chk("bp_hold_data", rdata, 32'd2);
      chk("bp_hold_last", rlast, 0);
      @(posedge clk); #2;
    end
    rready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("bp_valid", rvalid, 1);
      chk("bp_data", rdata, 32'(i + 1));
      chk("bp_last", rlast, (i == 3));
      @(posedge clk); #2;
    end
    chk("bp_done", rvalid, 0);
    rready = 1'b0;

    // Reset during beat 2 of a 4-beat read
    @(posedge clk); #1;
    araddr = 32'h1FC0_0100; arlen = 4'd3; arburst = INCR; arvalid = 1'b1;
    #1;
    chk("mid_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("mid_beat2", rdata, 32'd3);
    rst = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rvalid", rvalid, 0);
    chk("mid_rlast", rlast, 0);
    axi_read(32'h1FC0_0100, 4'd3, INCR);
    chk("post_d0", rd_dat[0], 32'd1);
    chk("post_d2", rd_dat[2], 32'd3);
    chk("post_d3", rd_dat[3], 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
